// File: rtl/note_pkg.sv
// Shared definitions for the two-voice song player: ROM entry layout,
// note codes and the code -> divider conversion.
package note_pkg;

  // Song ROM entry: [13:9] left code, [8:4] right code, [3:0] duration in beats
  localparam int ENTRY_W   = 14;
  localparam int CODE_W    = 5;
  localparam int DUR_W     = 4;
  localparam int LCODE_LSB = 9;
  localparam int RCODE_LSB = 4;
  localparam int DUR_LSB   = 0;

  localparam int DIV_W     = 22;
  localparam int NUM_CODES = 32;

  // Code 0 is a rest; codes 25..31 are unused and also silent
  typedef enum logic [CODE_W-1:0] {
    REST, C4, CS4, D4, DS4, E4, F4, FS4, G4, GS4, A4, AS4, B4,
    C5, CS5, D5, DS5, E5, F5, FS5, G5, GS5, A5, AS5, B5
  } note_code_e;

  // 32-entry code -> frequency table (integer Hz, equal temperament)
  function automatic int unsigned code_to_freq(input logic [CODE_W-1:0] code);
    case (code)
      5'd1:  return 262;  5'd2:  return 277;  5'd3:  return 294;  5'd4:  return 311;
      5'd5:  return 330;  5'd6:  return 349;  5'd7:  return 370;  5'd8:  return 392;
      5'd9:  return 415;  5'd10: return 440;  5'd11: return 466;  5'd12: return 494;
      5'd13: return 523;  5'd14: return 554;  5'd15: return 587;  5'd16: return 622;
      5'd17: return 659;  5'd18: return 698;  5'd19: return 740;  5'd20: return 784;
      5'd21: return 831;  5'd22: return 880;  5'd23: return 932;  5'd24: return 988;
      default: return 0;
    endcase
  endfunction

  // Divider for one note code; silent codes give 0
  function automatic logic [DIV_W-1:0] code_to_div(input logic [CODE_W-1:0] code,
                                                   input int unsigned clk_freq);
    int unsigned f;
    f = code_to_freq(code);
    if (f == 0) return '0;
    return DIV_W'(clk_freq / f);
  endfunction

  // All 32 dividers packed together, evaluated at elaboration so no divider is built
  function automatic logic [NUM_CODES*DIV_W-1:0] build_div_tbl(input int unsigned clk_freq);
    logic [NUM_CODES*DIV_W-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_CODES; i++) t[i*DIV_W +: DIV_W] = code_to_div(CODE_W'(i), clk_freq);
    return t;
  endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// Synchronous-read song ROM, one cycle of read latency. The song image is
// handed in as a packed parameter (entry i at bits [i*ENTRY_W +: ENTRY_W]).
module song_rom import note_pkg::*; #(
  parameter int SONG_LEN = 128,
  parameter int ADDR_W   = 7,
  parameter logic [SONG_LEN*ENTRY_W-1:0] ROM_INIT = '0
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] data_d, data_q;

  // Entry lookup; addresses past the song read as the end marker
  always_comb begin
    data_d = '0;
    if (int'(addr) < SONG_LEN) data_d = ROM_INIT[int'(addr)*ENTRY_W +: ENTRY_W];
  end

  // Registered read port
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/note_sequencer.sv
// Two-voice song player: fetches entries from the song ROM, times each note
// in beats, silences the tail of each note and drives the speaker dividers.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | stopped, outputs silent, waits for play
//   FETCH   | ROM address presented
//   LOAD    | ROM data valid; latch note or handle end marker
//   PLAY    | note sounding, tick/beat counters running
//   PAUSED  | counters frozen, outputs silent, waits for play
//   DONE    | song finished (done pulses on entry), waits for play
module note_sequencer import note_pkg::*; #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BEAT_TICKS = 6_250_000,
  parameter int GAP_TICKS  = 500_000,
  parameter int SONG_LEN   = 128,
  parameter int ADDR_W     = 7,
  parameter int LOOP       = 0,
  parameter logic [SONG_LEN*ENTRY_W-1:0] ROM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  output logic [DIV_W-1:0]  left_note_div,
  output logic [DIV_W-1:0]  right_note_div,
  output logic [ADDR_W-1:0] note_idx,
  output logic              playing,
  output logic              done
);

  localparam int TICK_W  = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam int NOTE_W  = $clog2(15 * BEAT_TICKS + 1);
  localparam int REM_W   = (NOTE_W > 26) ? NOTE_W : 26;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(BEAT_TICKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [NUM_CODES*DIV_W-1:0] DIV_TBL = build_div_tbl(CLK_FREQ);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_PAUSED, S_DONE} state_e;

  state_e              state_d, state_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [CODE_W-1:0]   lcode_d, lcode_q, rcode_d, rcode_q;
  logic [DUR_W-1:0]    dur_d, dur_q, beat_d, beat_q;
  logic [TICK_W-1:0]   tick_d, tick_q;
  logic [DIV_W-1:0]    ldiv_d, ldiv_q, rdiv_d, rdiv_q;
  logic                done_d, done_q;

  logic [ENTRY_W-1:0]  rom_data;
  logic                note_last;
  logic [DUR_W-1:0]    beats_left;
  logic [TICK_W-1:0]   ticks_left;
  logic [REM_W-1:0]    rem_d;
  logic                gap_en, sound;

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .ADDR_W   (ADDR_W),
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (rom_data)
  );

  assign note_last = (tick_q == LAST_TICK) && (beat_q == dur_q - DUR_W'(1));

  // Next-state, counters, and registered-output values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lcode_d = lcode_q;
    rcode_d = rcode_q;
    dur_d   = dur_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (play) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_data[DUR_LSB +: DUR_W] == '0) begin
          if (LOOP != 0) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          lcode_d = rom_data[LCODE_LSB +: CODE_W];
          rcode_d = rom_data[RCODE_LSB +: CODE_W];
          dur_d   = rom_data[DUR_LSB +: DUR_W];
          tick_d  = '0;
          beat_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (pause) begin
          state_d = S_PAUSED;
        end else if (note_last) begin
          // The entry after the last ROM slot is treated as the end marker
          if (addr_q == LAST_ADDR) begin
            if (LOOP != 0) begin
              addr_d  = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else if (tick_q == LAST_TICK) begin
          tick_d = '0;
          beat_d = beat_q + DUR_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_PAUSED: begin
        if (play) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      tick_d  = '0;
      beat_d  = '0;
    end

    // Outputs follow the state being entered, so gap timing uses next counters
    beats_left = dur_d - beat_d - DUR_W'(1);
    ticks_left = LAST_TICK - tick_d;
    rem_d  = REM_W'(beats_left) * REM_W'(BEAT_TICKS) + REM_W'(ticks_left);
    gap_en = (REM_W'(dur_d) * REM_W'(BEAT_TICKS)) > REM_W'(GAP_TICKS);
    sound  = (state_d == S_PLAY) && !(gap_en && (rem_d < REM_W'(GAP_TICKS)));
    ldiv_d = sound ? DIV_TBL[int'(lcode_d)*DIV_W +: DIV_W] : '0;
    rdiv_d = sound ? DIV_TBL[int'(rcode_d)*DIV_W +: DIV_W] : '0;
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lcode_q <= '0;
      rcode_q <= '0;
      dur_q   <= '0;
      tick_q  <= '0;
      beat_q  <= '0;
      ldiv_q  <= '0;
      rdiv_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lcode_q <= lcode_d;
      rcode_q <= rcode_d;
      dur_q   <= dur_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      ldiv_q  <= ldiv_d;
      rdiv_q  <= rdiv_d;
      done_q  <= done_d;
    end
  end

  assign left_note_div  = ldiv_q;
  assign right_note_div = rdiv_q;
  assign note_idx       = addr_q;
  assign playing        = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);
  assign done           = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: three instances (song A, song A looping,
// full ROM of one-beat notes) share the control inputs; each test checks one.
module tb_note_sequencer;
  import note_pkg::*;

  localparam logic [21:0] DA4 = 22'd227272;
  localparam logic [21:0] DC4 = 22'd381679;
  localparam logic [21:0] DC5 = 22'd191204;

  localparam logic [111:0] SONG_A = {{6{14'h0}},
                                     {5'(REST), 5'(C5), 4'd1},
                                     {5'(A4),   5'(C4), 4'd2}};
  localparam logic [111:0] SONG_C = {8{{5'(C4), 5'(REST), 4'd1}}};

  logic clk, rst, play, pause, stop;
  logic [21:0] l_a, r_a, l_b, r_b, l_c, r_c;
  logic [2:0]  i_a, i_b, i_c;
  logic        p_a, p_b, p_c, d_a, d_b, d_c;
  wire  [48:0] obs_a = {l_a, r_a, i_a, p_a, d_a};
  wire  [48:0] obs_b = {l_b, r_b, i_b, p_b, d_b};
  wire  [48:0] obs_c = {l_c, r_c, i_c, p_c, d_c};

  logic [48:0] sb[$];
  logic [48:0] exp_v;
  int total = 0;
  int bad   = 0;

  note_sequencer #(.CLK_FREQ(100_000_000), .BEAT_TICKS(10), .GAP_TICKS(2), .SONG_LEN(8),
                   .ADDR_W(3), .LOOP(0), .ROM_INIT(SONG_A)) dut_a (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .left_note_div(l_a), .right_note_div(r_a), .note_idx(i_a), .playing(p_a), .done(d_a));

  note_sequencer #(.CLK_FREQ(100_000_000), .BEAT_TICKS(10), .GAP_TICKS(2), .SONG_LEN(8),
                   .ADDR_W(3), .LOOP(1), .ROM_INIT(SONG_A)) dut_b (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .left_note_div(l_b), .right_note_div(r_b), .note_idx(i_b), .playing(p_b), .done(d_b));

  note_sequencer #(.CLK_FREQ(100_000_000), .BEAT_TICKS(10), .GAP_TICKS(2), .SONG_LEN(8),
                   .ADDR_W(3), .LOOP(0), .ROM_INIT(SONG_C)) dut_c (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .left_note_div(l_c), .right_note_div(r_c), .note_idx(i_c), .playing(p_c), .done(d_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_n(input int n, input logic [21:0] l, input logic [21:0] r,
                        input logic [2:0] idx, input logic pl, input logic dn);
    for (int i = 0; i < n; i++) sb.push_back({l, r, idx, pl, dn});
  endtask

  // Reset for one edge; returns in "cycle 0" with all controls low
  task automatic do_reset();
    rst = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Song A expectations from the first FETCH to the LOAD of the end marker (cycles 1..36)
  task automatic push_song_a_body();
    push_n(2,  0,   0,   3'd0, 1, 0);
    push_n(18, DA4, DC4, 3'd0, 1, 0);
    push_n(2,  0,   0,   3'd0, 1, 0);
    push_n(2,  0,   0,   3'd1, 1, 0);
    push_n(8,  0,   DC5, 3'd1, 1, 0);
    push_n(2,  0,   0,   3'd1, 1, 0);
    push_n(2,  0,   0,   3'd2, 1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; play = 1'b1; pause = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1; play = 1'b0;
    @(negedge clk);
    push_n(3, 0, 0, 3'd0, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs_a !== exp_v) begin bad++; $display("FAIL reset_a got=%h want=%h", obs_a, exp_v); end
    exp_v = sb.pop_front(); total++;
    if (obs_b !== exp_v) begin bad++; $display("FAIL reset_b got=%h want=%h", obs_b, exp_v); end
    exp_v = sb.pop_front(); total++;
    if (obs_c !== exp_v) begin bad++; $display("FAIL reset_c got=%h want=%h", obs_c, exp_v); end
  endtask

  // Full song A; a stray play in PLAY and a pause in DONE must both be ignored
  task automatic test_basic();
    int c;
    do_reset();
    play = 1'b1;
    push_song_a_body();
    push_n(1, 0, 0, 3'd2, 0, 1);
    push_n(3, 0, 0, 3'd2, 0, 0);
    c = 0;
    while (sb.size() != 0) begin
      c++;
      @(posedge clk); #1;
      play  = (c == 10);
      pause = (c == 39);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_a !== exp_v) begin bad++; $display("FAIL basic cyc=%0d got=%h want=%h", c, obs_a, exp_v); end
    end
  endtask

  // Pause with tick=5 in note 1, 20 paused cycles, then 15 PLAY cycles remain
  task automatic test_pause();
    int c;
    do_reset();
    play = 1'b1;
    push_n(2,  0,   0,   3'd0, 1, 0);
    push_n(6,  DA4, DC4, 3'd0, 1, 0);
    push_n(20, 0,   0,   3'd0, 0, 0);
    push_n(13, DA4, DC4, 3'd0, 1, 0);
    push_n(2,  0,   0,   3'd0, 1, 0);
    push_n(2,  0,   0,   3'd1, 1, 0);
    push_n(8,  0,   DC5, 3'd1, 1, 0);
    push_n(2,  0,   0,   3'd1, 1, 0);
    push_n(2,  0,   0,   3'd2, 1, 0);
    push_n(1,  0,   0,   3'd2, 0, 1);
    push_n(1,  0,   0,   3'd2, 0, 0);
    c = 0;
    while (sb.size() != 0) begin
      c++;
      @(posedge clk); #1;
      pause = (c == 8);
      play  = (c == 28);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_a !== exp_v) begin bad++; $display("FAIL pause cyc=%0d got=%h want=%h", c, obs_a, exp_v); end
    end
  endtask

  // stop + pause + play together in PLAY: stop wins, no done
  task automatic test_stop();
    int c;
    do_reset();
    play = 1'b1;
    push_n(2, 0,   0,   3'd0, 1, 0);
    push_n(4, DA4, DC4, 3'd0, 1, 0);
    push_n(4, 0,   0,   3'd0, 0, 0);
    c = 0;
    while (sb.size() != 0) begin
      c++;
      @(posedge clk); #1;
      stop  = (c == 6);
      pause = (c == 6);
      play  = (c == 6);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_a !== exp_v) begin bad++; $display("FAIL stop cyc=%0d got=%h want=%h", c, obs_a, exp_v); end
    end
  endtask

  // rst during note 2 silences at once; a new play restarts from entry 0
  task automatic test_rst_mid();
    int c;
    do_reset();
    play = 1'b1;
    push_n(2,  0,   0,   3'd0, 1, 0);
    push_n(18, DA4, DC4, 3'd0, 1, 0);
    push_n(2,  0,   0,   3'd0, 1, 0);
    push_n(2,  0,   0,   3'd1, 1, 0);
    push_n(3,  0,   DC5, 3'd1, 1, 0);
    push_n(3,  0,   0,   3'd0, 0, 0);
    push_n(2,  0,   0,   3'd0, 1, 0);
    push_n(3,  DA4, DC4, 3'd0, 1, 0);
    c = 0;
    while (sb.size() != 0) begin
      c++;
      @(posedge clk); #1;
      rst  = (c == 27);
      play = (c == 30);
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_a !== exp_v) begin bad++; $display("FAIL rst_mid cyc=%0d got=%h want=%h", c, obs_a, exp_v); end
    end
  endtask

  // LOOP=1: end marker sends the song back to entry 0, done never pulses
  task automatic test_loop();
    int c;
    do_reset();
    play = 1'b1;
    push_song_a_body();
    push_n(2, 0,   0,   3'd0, 1, 0);
    push_n(4, DA4, DC4, 3'd0, 1, 0);
    c = 0;
    while (sb.size() != 0) begin
      c++;
      @(posedge clk); #1;
      play = 1'b0;
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_b !== exp_v) begin bad++; $display("FAIL loop cyc=%0d got=%h want=%h", c, obs_b, exp_v); end
    end
  endtask

  // Eight one-beat entries: after entry 7 go to DONE without wrapping
  task automatic test_full_rom();
    int c;
    do_reset();
    play = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push_n(2, 0,   0, 3'(k), 1, 0);
      push_n(8, DC4, 0, 3'(k), 1, 0);
      push_n(2, 0,   0, 3'(k), 1, 0);
    end
    push_n(1, 0, 0, 3'd7, 0, 1);
    push_n(2, 0, 0, 3'd7, 0, 0);
    c = 0;
    while (sb.size() != 0) begin
      c++;
      @(posedge clk); #1;
      play = 1'b0;
      @(negedge clk);
      exp_v = sb.pop_front(); total++;
      if (obs_c !== exp_v) begin bad++; $display("FAIL full_rom cyc=%0d got=%h want=%h", c, obs_c, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_stop();
    test_rst_mid();
    test_loop();
    test_full_rom();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
